// File: rtl/rr_arb5_defs.sv
// Shared definitions for the five-way round-robin arbiter: state encodings,
// requester count and the rotate-and-pick search used by rr_pick5.
package rr_arb5_defs;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] OWN  = 1'b1;

   localparam int N_REQ = 5;

   typedef struct packed {
      logic [N_REQ-1:0] onehot;
      logic [2:0]       idx;
      logic             valid;
   } pick_t;

   // Search req starting at ptr and wrapping modulo 5; the first set bit wins.
   // Pointer codes 5-7 cannot occur in the arbiter; they fold to 0 so the
   // search never indexes past requester 4.
   function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                     input logic [2:0]       ptr);
      pick_t      r;
      logic [3:0] base;
      logic [3:0] cand;
      r    = '0;
      base = (ptr < 3'd5) ? {1'b0, ptr} : 4'd0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = base + 4'(i);
         if (cand >= 4'd5) cand = cand - 4'd5;
         if (!r.valid && req[cand[2:0]]) begin
            r.valid  = 1'b1;
            r.idx    = cand[2:0];
            r.onehot = 5'b00001 << cand[2:0];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_pick5.sv
// Combinational rotate-and-pick: first requester at or after the pointer.
module rr_pick5
   import rr_arb5_defs::*;
(
   input  logic [N_REQ-1:0] req_i,
   input  logic [2:0]       ptr_i,
   output logic [N_REQ-1:0] onehot_o,
   output logic [2:0]       idx_o,
   output logic             valid_o
);

   pick_t pick;

   // Evaluate the shared search function on the live request vector.
   always_comb begin
      pick = rr_pick(req_i, ptr_i);
   end

   assign onehot_o = pick.onehot;
   assign idx_o    = pick.idx;
   assign valid_o  = pick.valid;

endmodule

// File: rtl/rr_arb5.sv
// Five-way round-robin arbiter with registered one-hot grant, release on
// DONE / owner withdrawal / optional hold timeout, and zero-bubble handover.
// Handshake: a requester holds REQ high until it sees its GNT bit; the owner
// keeps REQ high while it uses the resource and releases it either by
// pulsing DONE or by dropping REQ. Both are sampled on the same rising edge.
module rr_arb5
   import rr_arb5_defs::*;
#(
   parameter int TMO_W   = 8,
   parameter int TMO_MAX = 0
) (
   input  logic             CK,
   input  logic             RSTN,
   input  logic [N_REQ-1:0] REQ,
   input  logic             DONE,
   output logic [N_REQ-1:0] GNT,
   output logic [2:0]       GID,
   output logic             BUSY,
   output logic             TOUT
);

   // A timeout that the counter can never reach is a build mistake.
   if (TMO_MAX < 0 || longint'(TMO_MAX) > ((longint'(1) << TMO_W) - 1)) begin : g_cfg_err
      $error("rr_arb5: TMO_MAX=%0d does not fit a %0d-bit hold counter", TMO_MAX, TMO_W);
   end

   localparam bit               TMO_EN   = (TMO_MAX != 0);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_MAX - 1);
   localparam logic [TMO_W-1:0] CNT_SAT  = '1;

   logic [0:0]       state_q, state_d;
   logic [2:0]       ptr_q,   ptr_d;
   logic [TMO_W-1:0] cnt_q,   cnt_d;
   logic [N_REQ-1:0] gnt_q,   gnt_d;
   logic [2:0]       gid_q,   gid_d;
   logic             tout_q,  tout_d;

   logic             owner_req;
   logic             tmo_hit;
   logic             rel;
   logic [N_REQ-1:0] arb_req;
   logic [N_REQ-1:0] pk_onehot;
   logic [2:0]       pk_idx;
   logic             pk_valid;

   // REQ[GID] expressed through the one-hot grant, so no variable index.
   assign owner_req = |(REQ & gnt_q);
   assign tmo_hit   = TMO_EN && (cnt_q == TMO_LAST);
   assign rel       = (state_q == OWN) && (DONE || !owner_req || tmo_hit);

   // While owning, the current owner is excluded from the re-arbitration
   // that happens on its releasing edge.
   assign arb_req = (state_q == OWN) ? (REQ & ~gnt_q) : REQ;

   rr_pick5 u_pick (
      .req_i    (arb_req),
      .ptr_i    (ptr_q),
      .onehot_o (pk_onehot),
      .idx_o    (pk_idx),
      .valid_o  (pk_valid)
   );

   // Next-state: grant from IDLE, hold or hand over from OWN.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
      gid_d   = gid_q;
      tout_d  = 1'b0;
      if (state_q == IDLE || rel) begin
         // DONE and withdrawal both take precedence over a coincident timeout.
         tout_d = rel && tmo_hit && !DONE && owner_req;
         if (pk_valid) begin
            state_d = OWN;
            gnt_d   = pk_onehot;
            gid_d   = pk_idx;
            cnt_d   = '0;
            ptr_d   = (pk_idx == 3'd4) ? 3'd0 : pk_idx + 3'd1;
         end else begin
            state_d = IDLE;
            gnt_d   = '0;
            gid_d   = 3'd0;
            cnt_d   = '0;
         end
      end else begin
         cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
      end
   end

   // State and output registers; reset wins over any release or grant.
   always_ff @(posedge CK) begin
      if (!RSTN) begin
         state_q <= IDLE;
         ptr_q   <= 3'd0;
         cnt_q   <= '0;
         gnt_q   <= '0;
         gid_q   <= 3'd0;
         tout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         gid_q   <= gid_d;
         tout_q  <= tout_d;
      end
   end

   assign GNT  = gnt_q;
   assign GID  = gid_q;
   assign BUSY = |gnt_q;
   assign TOUT = tout_q;

endmodule
